// File: rtl/alarm_ctrl.sv
// Alarm controller fed by the hrs_min_sec counter: stores an alarm time, rings for RING_SECS seconds on match.
// Optional snooze (SNOOZE state and counter) is built only when ALARM_SNOOZE_EN is defined.
module alarm_ctrl #(
  parameter int O           = 6,
  parameter int P           = 5,
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [P-1:0] hrs,
  input  logic [O-1:0] min,
  input  logic [O-1:0] sec,
  input  logic         set_valid,
  output logic         set_ready,
  input  logic [P-1:0] set_hrs,
  input  logic [O-1:0] set_min,
  input  logic         arm,
  input  logic         stop,
  input  logic         snooze,
  output logic         ringing,
  output logic         armed
);

  localparam int RING_W = $clog2(RING_SECS + 1);
  localparam logic [RING_W-1:0] RING_INIT = RING_W'(RING_SECS);

`ifdef ALARM_SNOOZE_EN
  typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZE} state_t;
  localparam int SNZ_W = $clog2(SNOOZE_SECS + 1);
  localparam logic [SNZ_W-1:0] SNZ_INIT = SNZ_W'(SNOOZE_SECS);
  logic [SNZ_W-1:0] snz_q, snz_d;
`else
  typedef enum logic [1:0] {IDLE, ARMED, RINGING} state_t;
  logic snooze_unused;
  assign snooze_unused = snooze;
`endif

  state_t              state_q, state_d;
  logic [RING_W-1:0]   ring_q, ring_d;
  logic [P-1:0]        alm_hrs;
  logic [O-1:0]        alm_min;
  logic [O-1:0]        sec_q;
  logic                sec_tick;
  logic                match;
  logic                load;

  // A second has elapsed whenever the counter's sec bus moves.
  assign sec_tick  = (sec != sec_q);
  assign match     = (hrs == alm_hrs) && (min == alm_min) && (sec == '0) && sec_tick;
  assign set_ready = (state_q == IDLE) || (state_q == ARMED);
  assign load      = set_valid && set_ready;
  assign ringing   = (state_q == RINGING);
  assign armed     = (state_q != IDLE);

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ring_q  <= '0;
      alm_hrs <= '0;
      alm_min <= '0;
      sec_q   <= '0;
`ifdef ALARM_SNOOZE_EN
      snz_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ring_q  <= ring_d;
      sec_q   <= sec;
`ifdef ALARM_SNOOZE_EN
      snz_q   <= snz_d;
`endif
      if (load) begin
        alm_hrs <= set_hrs;
        alm_min <= set_min;
      end
    end
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
`ifdef ALARM_SNOOZE_EN
    snz_d   = snz_q;
`endif
    case (state_q)
      IDLE: begin
        if (arm) state_d = ARMED;
      end
      ARMED: begin
        if (!arm) begin
          state_d = IDLE;
        end else if (match) begin
          state_d = RINGING;
          ring_d  = RING_INIT;
        end
      end
      RINGING: begin
        if (stop) begin
          state_d = arm ? ARMED : IDLE;
        end else if (!arm) begin
          state_d = IDLE;
`ifdef ALARM_SNOOZE_EN
        end else if (snooze) begin
          state_d = SNOOZE;
          snz_d   = SNZ_INIT;
`endif
        end else if (sec_tick) begin
          ring_d = (ring_q != '0) ? ring_q - RING_W'(1) : '0;
          if (ring_q == RING_W'(1)) state_d = ARMED;
        end
      end
`ifdef ALARM_SNOOZE_EN
      SNOOZE: begin
        if (stop) begin
          state_d = arm ? ARMED : IDLE;
        end else if (!arm) begin
          state_d = IDLE;
        end else if (sec_tick) begin
          snz_d = (snz_q != '0) ? snz_q - SNZ_W'(1) : '0;
          if (snz_q == SNZ_W'(1)) begin
            state_d = RINGING;
            ring_d  = RING_INIT;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Bench for alarm_ctrl: directed vector table, hand-written snooze/reset sequences, then random stimulus vs. a model.
// Snooze expectations follow ALARM_SNOOZE_EN, matching the RTL build.
module tb_alarm_ctrl;
  localparam int O    = 6;
  localparam int P    = 5;
  localparam int RING = 3;
  localparam int SNZ  = 2;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ_EN = 1'b1;
`else
  localparam bit SNZ_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [P-1:0] hrs = '0;
  logic [O-1:0] min = '0;
  logic [O-1:0] sec = '0;
  logic         set_valid = 1'b0;
  logic         set_ready;
  logic [P-1:0] set_hrs = '0;
  logic [O-1:0] set_min = '0;
  logic         arm = 1'b0;
  logic         stop = 1'b0;
  logic         snooze = 1'b0;
  logic         ringing;
  logic         armed;

  int n_checks = 0;
  int n_fail   = 0;

  alarm_ctrl #(.O(O), .P(P), .RING_SECS(RING), .SNOOZE_SECS(SNZ)) dut (
    .clk(clk), .rst(rst), .hrs(hrs), .min(min), .sec(sec),
    .set_valid(set_valid), .set_ready(set_ready), .set_hrs(set_hrs), .set_min(set_min),
    .arm(arm), .stop(stop), .snooze(snooze), .ringing(ringing), .armed(armed)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Behavioural model: alarm on/off, sounding, snoozing, and seconds left in each.
  int m_prev_sec, m_ah, m_am, m_ring_left, m_snz_left;
  bit m_on, m_ringing, m_snoozing;

  function automatic void model_reset();
    m_prev_sec = 0; m_ah = 0; m_am = 0; m_ring_left = 0; m_snz_left = 0;
    m_on = 0; m_ringing = 0; m_snoozing = 0;
  endfunction

  function automatic void model_step();
    bit tick, hit, can_load;
    tick     = (int'(sec) != m_prev_sec);
    hit      = tick && (sec == 0) && (int'(hrs) == m_ah) && (int'(min) == m_am);
    can_load = !(m_ringing || m_snoozing);
    if (set_valid && can_load) begin
      m_ah = int'(set_hrs);
      m_am = int'(set_min);
    end
    if (!m_on) begin
      m_on = arm;
    end else if (m_ringing) begin
      if (stop) begin
        m_ringing = 0; m_on = arm;
      end else if (!arm) begin
        m_ringing = 0; m_on = 0;
      end else if (SNZ_EN && snooze) begin
        m_ringing = 0; m_snoozing = 1; m_snz_left = SNZ;
      end else if (tick) begin
        m_ring_left--;
        if (m_ring_left == 0) m_ringing = 0;
      end
    end else if (m_snoozing) begin
      if (stop) begin
        m_snoozing = 0; m_on = arm;
      end else if (!arm) begin
        m_snoozing = 0; m_on = 0;
      end else if (tick) begin
        m_snz_left--;
        if (m_snz_left == 0) begin
          m_snoozing = 0; m_ringing = 1; m_ring_left = RING;
        end
      end
    end else begin
      if (!arm) m_on = 0;
      else if (hit) begin
        m_ringing = 1; m_ring_left = RING;
      end
    end
    m_prev_sec = int'(sec);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input int r, input int a, input int s);
    check({name, ".ringing"}, int'(ringing), r);
    check({name, ".armed"}, int'(armed), a);
    check({name, ".set_ready"}, int'(set_ready), s);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [P-1:0] hrs;
    logic [O-1:0] min;
    logic [O-1:0] sec;
    logic         sv;
    logic [P-1:0] sh;
    logic [O-1:0] sm;
    logic         arm;
    logic         stop;
    logic         snz;
    logic         e_ring;
    logic         e_armed;
    logic         e_ready;
  } vec_t;

  function automatic vec_t mk(int h, int m, int s, bit v, int sh, int sm,
                              bit a, bit st, bit sz, bit er, bit ea, bit ey);
    vec_t t;
    t.hrs = P'(h); t.min = O'(m); t.sec = O'(s);
    t.sv = v; t.sh = P'(sh); t.sm = O'(sm);
    t.arm = a; t.stop = st; t.snz = sz;
    t.e_ring = er; t.e_armed = ea; t.e_ready = ey;
    return t;
  endfunction

  vec_t vecs[25];

  initial begin
    vecs[0]  = mk(1, 1, 58, 1, 1, 2, 0, 0, 0, 0, 0, 1); // load 1:02 while idle
    vecs[1]  = mk(1, 1, 58, 0, 0, 0, 1, 0, 0, 0, 1, 1);
    vecs[2]  = mk(1, 1, 59, 0, 0, 0, 1, 0, 0, 0, 1, 1);
    vecs[3]  = mk(1, 2,  0, 0, 0, 0, 1, 0, 0, 1, 1, 0); // match -> ringing
    vecs[4]  = mk(1, 2,  0, 0, 0, 0, 1, 0, 0, 1, 1, 0);
    vecs[5]  = mk(1, 2,  1, 0, 0, 0, 1, 0, 0, 1, 1, 0);
    vecs[6]  = mk(1, 2,  1, 0, 0, 0, 1, 0, 0, 1, 1, 0);
    vecs[7]  = mk(1, 2,  2, 0, 0, 0, 1, 0, 0, 1, 1, 0);
    vecs[8]  = mk(1, 2,  3, 0, 0, 0, 1, 0, 0, 0, 1, 1); // third tick -> timeout
    vecs[9]  = mk(1, 2,  3, 0, 0, 0, 1, 0, 0, 0, 1, 1);
    vecs[10] = mk(1, 2,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1); // match with arm=0 -> idle
    vecs[11] = mk(1, 2,  0, 0, 0, 0, 1, 0, 0, 0, 1, 1);
    vecs[12] = mk(1, 2,  1, 0, 0, 0, 1, 0, 0, 0, 1, 1);
    vecs[13] = mk(1, 2,  0, 0, 0, 0, 1, 0, 0, 1, 1, 0);
    vecs[14] = mk(1, 2,  0, 0, 0, 0, 1, 1, 1, 0, 1, 1); // stop beats snooze
    vecs[15] = mk(1, 2,  1, 0, 0, 0, 1, 0, 0, 0, 1, 1);
    vecs[16] = mk(1, 2,  0, 0, 0, 0, 1, 0, 0, 1, 1, 0);
    vecs[17] = mk(1, 2,  0, 1, 3, 4, 1, 0, 0, 1, 1, 0); // load request held off
    vecs[18] = mk(1, 2,  0, 1, 3, 4, 1, 1, 0, 0, 1, 1);
    vecs[19] = mk(1, 2,  0, 1, 3, 4, 1, 0, 0, 0, 1, 1); // transfer happens here
    vecs[20] = mk(1, 2,  1, 0, 0, 0, 1, 0, 0, 0, 1, 1);
    vecs[21] = mk(1, 2,  0, 0, 0, 0, 1, 0, 0, 0, 1, 1); // old time no longer rings
    vecs[22] = mk(3, 4,  1, 0, 0, 0, 1, 0, 0, 0, 1, 1);
    vecs[23] = mk(3, 4,  0, 0, 0, 0, 1, 0, 0, 1, 1, 0);
    vecs[24] = mk(3, 4,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1); // arm drop silences

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 0, 0, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 25; i++) begin
      hrs = vecs[i].hrs; min = vecs[i].min; sec = vecs[i].sec;
      set_valid = vecs[i].sv; set_hrs = vecs[i].sh; set_min = vecs[i].sm;
      arm = vecs[i].arm; stop = vecs[i].stop; snooze = vecs[i].snz;
      step();
      check_out($sformatf("vec%0d", i), int'(vecs[i].e_ring), int'(vecs[i].e_armed),
                int'(vecs[i].e_ready));
    end
    set_valid = 0; stop = 0; snooze = 0;

    // Snooze sequence, alarm at 3:04.
    arm = 1; step();
    check_out("snz_arm", 0, 1, 1);
    sec = 1; step();
    sec = 0; step();
    check_out("snz_ring", 1, 1, 0);
    snooze = 1; step(); snooze = 0;
    if (SNZ_EN) check_out("snz_pulse", 0, 1, 0);
    else        check_out("snz_pulse", 1, 1, 0);
    sec = 1; step();
    if (SNZ_EN) check_out("snz_tick1", 0, 1, 0);
    else        check_out("snz_tick1", 1, 1, 0);
    sec = 2; step();
    check_out("snz_tick2", 1, 1, 0);

    // Asynchronous reset mid-ringing, away from any clock edge.
    #2;
    rst = 1'b0;
    #1;
    check_out("async_rst", 0, 0, 1);
    model_reset();
    hrs = 0; min = 0; sec = 0; arm = 0;
    @(negedge clk);
    rst = 1'b1;

    // Random phase: small value ranges so matches, ticks and handshakes are frequent.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) == 0) sec = O'($urandom_range(0, 2));
      if ($urandom_range(0, 15) == 0) hrs = P'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) min = O'($urandom_range(0, 1));
      arm       = ($urandom_range(0, 19) != 0);
      stop      = ($urandom_range(0, 24) == 0);
      snooze    = ($urandom_range(0, 9) == 0);
      set_valid = ($urandom_range(0, 14) == 0);
      set_hrs   = P'($urandom_range(0, 1));
      set_min   = O'($urandom_range(0, 1));
      step();
      check_out($sformatf("rnd%0d", c), int'(m_ringing), int'(m_on),
                int'(!(m_ringing || m_snoozing)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
- Downstream consumer of the hrs_min_sec time-of-day counter.
- Compares the live hrs/min/sec outputs against a stored alarm time and drives a ringing output for a bounded number of seconds.
- Optional snooze re-triggers the alarm after a delay.
- Alarm time is loaded through a valid/ready handshake. Seconds are timed by detecting changes on the counter's sec bus, so no separate tick port is needed.

Parameters:
- O, 6, width of min and sec buses (matches counter O).
- P, 5, width of hrs bus (matches counter P).
- RING_SECS, 60, seconds ringing lasts before auto-timeout (≥1).
- SNOOZE_SECS, 300, snooze delay in seconds (≥1).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous active-low reset (0 = reset).
- hrs  in  P  current hours from counter.
- min  in  O  current minutes from counter.
- sec  in  O  current seconds from counter.
- set_valid  in  1  alarm-time load request.
- set_ready  out  1  block can accept a load.
- set_hrs  in  P  alarm hours, sampled on transfer.
- set_min  in  O  alarm minutes, sampled on transfer.
- arm  in  1  level; 1 = alarm enabled.
- stop  in  1  single-cycle pulse; silence alarm.
- snooze  in  1  single-cycle pulse; snooze request (used only with feature).
- ringing  out  1  alarm sounding.
- armed  out  1  high in any state except IDLE.

Behaviour:
- Reset (rst=0, async): state=IDLE, alm_hrs=0, alm_min=0, sec_q=0, ring_cnt=0, snz_cnt=0. Outputs: ringing=0, armed=0, set_ready=1.
- sec_q registers sec every cycle. sec_tick = (sec != sec_q), combinational.
- match = (hrs==alm_hrs) && (min==alm_min) && (sec==0) && sec_tick. Raw compare; no range checking.
- set_ready = 1 in IDLE/ARMED, 0 in RINGING/SNOOZE.
- Transfer occurs when set_valid && set_ready: alm_hrs/alm_min load at that edge and state is unchanged. set_valid held while set_ready=0 waits; data must stay stable until transfer.
- States: IDLE, ARMED, RINGING, SNOOZE. All transitions are registered.
- IDLE -> ARMED when arm=1.
- ARMED:
  - -> IDLE when arm=0.
  - -> RINGING on match; ring_cnt=RING_SECS.
- RINGING: priority stop > arm=0 > snooze > timeout.
  - stop -> ARMED if arm=1, else IDLE.
  - arm=0 -> IDLE.
  - snooze -> SNOOZE (feature only); snz_cnt=SNOOZE_SECS.
  - On sec_tick: ring_cnt decrements. A sec_tick with ring_cnt==1 -> ARMED (auto timeout).
- SNOOZE:
  - stop -> ARMED if arm=1, else IDLE.
  - arm=0 -> IDLE.
  - On sec_tick: snz_cnt decrements. A sec_tick with snz_cnt==1 -> RINGING; ring_cnt=RING_SECS.
- Outputs are registered decodes of state: ringing = (state==RINGING), armed = (state!=IDLE).
- Latency: ringing rises on the first clk edge after sec becomes 0 at the matching hrs:min. That is one cycle after the counter update.
- Simultaneous events:
  - match in ARMED with arm=0: IDLE wins.
  - stop and snooze in the same cycle: stop wins.
  - A new match while RINGING or SNOOZE is ignored.
- ring_cnt/snz_cnt widths are $clog2(RING_SECS+1) and $clog2(SNOOZE_SECS+1). Decrement never goes below 0.
- Reset mid-operation returns to IDLE immediately, asynchronously. ringing drops without waiting for clk.

Optional Feature:
- ALARM_SNOOZE_EN defined: SNOOZE state and snz_cnt are implemented per the Behaviour section.
- ALARM_SNOOZE_EN undefined: no SNOOZE state or snz_cnt. The snooze port remains but is ignored; snooze in RINGING has no effect.

Test Plan:
- Load alarm via handshake: set_hrs=1, set_min=2 with set_valid=1 while IDLE -> set_ready=1, alm registers = 1:02.
- arm=1, bench drives counter buses 1:01:59 -> 1:02:00 -> ringing=1 on the next edge, set_ready=0, armed=1.
- RING_SECS=3, no stop -> ringing stays high for 3 sec changes, then the state returns to ARMED with ringing=0.
- Ringing with stop and snooze pulsed in the same cycle -> stop wins: ARMED, ringing=0.
- Snooze test (ALARM_SNOOZE_EN, SNOOZE_SECS=2):
  - snooze pulse during RINGING -> SNOOZE, ringing=0.
  - After 2 sec ticks -> RINGING again.
  - Without the macro, the same pulse leaves ringing=1.
- rst=0 asserted mid-RINGING, asynchronous to clk -> ringing=0, armed=0, set_ready=1 immediately.
- set_valid during RINGING -> set_ready=0 and the alarm time is unchanged; the held request transfers after stop.
